// File: rtl/btn_event.sv
// btn_event
//   Turns a debounced, CLK-synchronous button level into registered events:
//   a press pulse, a release pulse, and a step strobe that fires on the press
//   and then auto-repeats while the button stays held. An 8-bit press count
//   wraps modulo 256 and is intended for display.
//
// Parameters
//   HOLD_CNT   cycles from the press step to the first auto-repeat step (>=2)
//   REPEAT_CNT cycles between successive auto-repeat steps (>=2)
//   CNT_W      interval counter width, 2^CNT_W >= max(HOLD_CNT, REPEAT_CNT)
//
// Ports
//   CLK          system clock, rising edge
//   RST_N        asynchronous active-low reset
//   BTN_I        debounced button level, 1 = pressed
//   PRESS_O      one-cycle pulse on press
//   RELEASE_O    one-cycle pulse on release
//   STEP_O       one-cycle pulse on press and on each auto-repeat
//   LONG_O       level, high while auto-repeat is active
//   PRESS_CNT_O  press count modulo 256
module btn_event #(
  parameter int HOLD_CNT   = 50_000_000,
  parameter int REPEAT_CNT = 10_000_000,
  parameter int CNT_W      = 26
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       BTN_I,
  output logic       PRESS_O,
  output logic       RELEASE_O,
  output logic       STEP_O,
  output logic       LONG_O,
  output logic [7:0] PRESS_CNT_O
);

  typedef enum logic [1:0] {IDLE, PRESSED, REPEAT} state_t;

  localparam logic [CNT_W-1:0] HOLD_TC   = CNT_W'(HOLD_CNT - 1);
  localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CNT - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             btn_q;

  logic             press_nx, release_nx, step_nx, long_nx;
  logic [7:0]       pcnt_nx;

  logic             press, rel;

  assign press = BTN_I & ~btn_q;
  assign rel   = ~BTN_I & btn_q;

  // State, counter and every output are registered here; the two comb
  // processes below only compute next values, so no output sees BTN_I
  // combinationally.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      cnt         <= '0;
      btn_q       <= 1'b0;
      PRESS_O     <= 1'b0;
      RELEASE_O   <= 1'b0;
      STEP_O      <= 1'b0;
      LONG_O      <= 1'b0;
      PRESS_CNT_O <= 8'd0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      btn_q       <= BTN_I;
      PRESS_O     <= press_nx;
      RELEASE_O   <= release_nx;
      STEP_O      <= step_nx;
      LONG_O      <= long_nx;
      PRESS_CNT_O <= pcnt_nx;
    end
  end

  // Next-state and interval counter. Release is tested before the terminal
  // count so a release on the repeat boundary never produces a step.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (press) begin
          state_nx = PRESSED;
          cnt_nx   = '0;
        end
      end
      PRESSED: begin
        if (rel) begin
          state_nx = IDLE;
        end else if (cnt == HOLD_TC) begin
          state_nx = REPEAT;
          cnt_nx   = '0;
        end else begin
          cnt_nx   = cnt + CNT_W'(1);
        end
      end
      REPEAT: begin
        if (rel) begin
          state_nx = IDLE;
        end else if (cnt == REPEAT_TC) begin
          cnt_nx   = '0;
        end else begin
          cnt_nx   = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Next output values. Pulses default low every cycle.
  always_comb begin
    press_nx   = 1'b0;
    release_nx = 1'b0;
    step_nx    = 1'b0;
    pcnt_nx    = PRESS_CNT_O;
    unique case (state)
      IDLE: begin
        if (press) begin
          press_nx = 1'b1;
          step_nx  = 1'b1;
          pcnt_nx  = PRESS_CNT_O + 8'd1;
        end
      end
      PRESSED: begin
        if (rel)                  release_nx = 1'b1;
        else if (cnt == HOLD_TC)  step_nx    = 1'b1;
      end
      REPEAT: begin
        if (rel)                  release_nx = 1'b1;
        else if (cnt == REPEAT_TC) step_nx   = 1'b1;
      end
      default: ;
    endcase
    // LONG_O tracks residency in the auto-repeat state.
    long_nx = (state_nx == REPEAT);
  end

endmodule

// File: tb/tb_btn_event.sv
module tb_btn_event;

  logic       CLK;
  logic       RST_N;
  logic       BTN_I;
  logic       PRESS_O, RELEASE_O, STEP_O, LONG_O;
  logic [7:0] PRESS_CNT_O;

  btn_event #(.HOLD_CNT(8), .REPEAT_CNT(4), .CNT_W(4)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .BTN_I      (BTN_I),
    .PRESS_O    (PRESS_O),
    .RELEASE_O  (RELEASE_O),
    .STEP_O     (STEP_O),
    .LONG_O     (LONG_O),
    .PRESS_CNT_O(PRESS_CNT_O)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Expected vector layout: {press, release, step, long, pcnt[7:0]}
  logic [11:0] exp_q[$];
  logic [7:0]  exp_pcnt;
  int          n_vec  = 0;
  int          n_miss = 0;
  int          cyc    = 0;

  function automatic logic [11:0] act_vec();
    return {PRESS_O, RELEASE_O, STEP_O, LONG_O, PRESS_CNT_O};
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s cyc=%0d got p/r/s/l=%b%b%b%b cnt=%0d want p/r/s/l=%b%b%b%b cnt=%0d",
               name, cyc, act[11], act[10], act[9], act[8], act[7:0],
               exp[11], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  // Monitor: outputs are valid every cycle, so one expectation is consumed
  // per clock whenever the driver has queued one.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      cyc++;
      if (exp_q.size() > 0) check("cycle", act_vec(), exp_q.pop_front());
    end
  end

  // BTN_I low for n cycles, no events expected.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      BTN_I = 1'b0;
      exp_q.push_back({4'b0000, exp_pcnt});
    end
  endtask

  // BTN_I high for len cycles. step_mask bit i = STEP_O expected after edge
  // e0+i; LONG_O expected high from e0+lstart. Optionally one release cycle.
  task automatic hold(input int len, input logic [31:0] step_mask,
                      input int lstart, input bit do_rel);
    for (int i = 0; i < len; i++) begin
      @(negedge CLK);
      BTN_I = 1'b1;
      if (i == 0) exp_pcnt = exp_pcnt + 8'd1;
      exp_q.push_back({(i == 0), 1'b0, step_mask[i], (i >= lstart), exp_pcnt});
    end
    if (do_rel) begin
      @(negedge CLK);
      BTN_I = 1'b0;
      exp_q.push_back({4'b0100, exp_pcnt});
    end
  endtask

  initial begin
    RST_N    = 1'b0;
    BTN_I    = 1'b0;
    exp_pcnt = 8'd0;
    #12;
    check("reset_state", act_vec(), 12'h000);
    @(negedge CLK);
    RST_N = 1'b1;
    idle(2);

    // Short press: 5 cycles high.
    hold(5, 32'h0000_0001, 1000, 1'b1);
    idle(2);

    // Long hold: steps at e0, e0+8, e0+12, e0+16; LONG from e0+8.
    hold(20, 32'h0001_1101, 8, 1'b1);
    idle(2);

    // Release on repeat terminal: steps at e0, e0+8 only.
    hold(12, 32'h0000_0101, 8, 1'b1);
    idle(2);

    // Back-to-back single-cycle presses: 1,0,1,0.
    hold(1, 32'h1, 1000, 1'b1);
    hold(1, 32'h1, 1000, 1'b1);
    idle(2);

    // Reset mid-REPEAT: hold 10 cycles (steps e0, e0+8; long from e0+8).
    hold(10, 32'h0000_0101, 8, 1'b0);
    @(posedge CLK);
    #2;
    RST_N = 1'b0;
    exp_pcnt = 8'd0;
    #1;
    check("async_reset", act_vec(), 12'h000);
    #1;
    // Leave reset with the button still high: the first edge is a press.
    RST_N = 1'b1;
    hold(3, 32'h1, 1000, 1'b1);
    idle(2);

    // Counter wrap: clear, then 256 single-cycle presses.
    @(posedge CLK);
    #2;
    RST_N = 1'b0;
    exp_pcnt = 8'd0;
    #1;
    check("wrap_reset", act_vec(), 12'h000);
    #1;
    RST_N = 1'b1;
    idle(1);
    for (int k = 0; k < 256; k++) hold(1, 32'h1, 1000, 1'b1);
    idle(2);

    // Drain the scoreboard with a bounded wait.
    for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(posedge CLK);
    #2;
    if (exp_q.size() > 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain got %0d pending want 0 pending", exp_q.size());
    end
    check("final_cnt", {4'b0000, PRESS_CNT_O}, 12'h000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
